trace_uart_logger: RTL

- Captures the 65C02 bus cycle by cycle: address, data, R/W and SYNC, sampled on each CPU clock enable.
- Buffers the captured records in a FIFO and streams them to a host as framed bytes on a dedicated 8N1 serial output.
- Sits directly downstream of the top-level CPU bus and trace signals. Consumes cpu_AB, the cpu_DI/cpu_DO mux result, cpu_WE, cpu_SYNC and cpu_clken.
- Gives a non-intrusive instruction/bus trace without a logic analyser.

---
 rtl/trace_uart_logger.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/trace_uart_logger.sv
// Bus trace logger: captures 65C02 bus cycles into a FIFO and streams them as framed 8N1 bytes.
// Optional feature macro TRACE_TIMESTAMP_EN adds a 16-bit clken timestamp (7-byte frames).
module trace_uart_logger #(
    parameter int CLKS_PER_BIT = 139,
    parameter int FIFO_AW      = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clken,
    input  logic               enable,
    input  logic               sync_only,
    input  logic [15:0]        cpu_ab,
    input  logic [7:0]         cpu_data,
    input  logic               cpu_rnw,
    input  logic               cpu_sync,
    output logic               txd,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [15:0]        drop_count
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int   REC_W   = 43;
    localparam int   NBYTES  = 7;
    localparam logic TS_FLAG = 1'b1;
`else
    localparam int   REC_W   = 27;
    localparam int   NBYTES  = 5;
    localparam logic TS_FLAG = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             state;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               ovf;
    logic               capture;
    logic               push;
    logic               pop;
    logic [REC_W-1:0]   new_rec;
    logic [REC_W-1:0]   hold;
    logic [2:0]         byte_idx;
    logic [2:0]         bit_idx;
    logic [CW-1:0]      tick;
    logic               tick_last;
    logic [7:0]         b0;
    logic [7:0]         checksum;
    logic [7:0]         cur_byte;

    // Record layout, LSB up: data, ab, rnw, sync, ovf, then timestamp when enabled.
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_count;

    always_ff @(posedge clk) begin
        if (!reset_n)
            ts_count <= '0;
        else if (clken)
            ts_count <= ts_count + 16'd1;
    end

    assign new_rec = {ts_count, ovf, cpu_sync, cpu_rnw, cpu_ab, cpu_data};
`else
    assign new_rec = {ovf, cpu_sync, cpu_rnw, cpu_ab, cpu_data};
`endif

    assign capture   = clken && enable && (!sync_only || cpu_sync);
    assign push      = capture && (fifo_level != (FIFO_AW+1)'(DEPTH));
    assign pop       = (state == S_IDLE) && (fifo_level != '0);
    assign tick_last = (tick == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= new_rec;
    end

    // Full is judged on the level at the start of the cycle, so a same-cycle pop never makes room.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
                ovf    <= 1'b0;
            end else if (capture) begin
                ovf <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_comb begin
        b0       = {4'hA, hold[26], hold[25], hold[24], TS_FLAG};
        checksum = b0 ^ hold[23:16] ^ hold[15:8] ^ hold[7:0];
`ifdef TRACE_TIMESTAMP_EN
        checksum = checksum ^ hold[42:35] ^ hold[34:27];
`endif
        cur_byte = checksum;
        case (byte_idx)
            3'd0:    cur_byte = b0;
            3'd1:    cur_byte = hold[23:16];
            3'd2:    cur_byte = hold[15:8];
            3'd3:    cur_byte = hold[7:0];
`ifdef TRACE_TIMESTAMP_EN
            3'd4:    cur_byte = hold[42:35];
            3'd5:    cur_byte = hold[34:27];
`endif
            default: cur_byte = checksum;
        endcase
    end

    // txd is registered, so the line follows the state by one clock; busy spans the whole frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            hold     <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            tick     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (fifo_level != '0) begin
                        hold     <= mem[rd_ptr];
                        busy     <= 1'b1;
                        byte_idx <= '0;
                        tick     <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    txd <= 1'b0;
                    if (tick_last) begin
                        tick    <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                S_DATA: begin
                    txd <= cur_byte[bit_idx];
                    if (tick_last) begin
                        tick <= '0;
                        if (bit_idx == 3'd7)
                            state <= S_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                S_STOP: begin
                    txd <= 1'b1;
                    if (tick_last) begin
                        tick <= '0;
                        if (byte_idx == 3'(NBYTES - 1)) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= S_START;
                        end
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
